// File: rtl/and16_rr_arbiter.sv
// Round-robin arbiter sharing one 16-input AND reduction among N_REQ requesters.
// Latency: grant 1 cycle after request, result 2 cycles after; one op per 2 cycles sustained.

module and16 (
   input  logic [15:0] a,
   output logic        y
);
   assign y = &a;
endmodule

module and16_rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [16*N_REQ-1:0]  req_data,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic                 rsp_y,
   output logic                 busy,
   output logic [15:0]          op_count
);
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t             r_state;
   logic [N_REQ-1:0]   r_gnt;
   logic [N_REQ-1:0]   r_rsp_valid;
   logic               r_rsp_y;
   logic               r_busy;
   logic [15:0]        r_op_count;
   logic [PTR_W-1:0]   r_ptr;
   logic [PTR_W-1:0]   r_idx;
   logic [15:0]        r_operand;

   logic               w_found;
   logic [PTR_W-1:0]   w_win;
   logic [PTR_W-1:0]   w_next_ptr;
   logic [N_REQ-1:0]   w_win_oh;
   logic [15:0]        w_win_data;
   logic               w_and_y;
   int                 w_idx;

   // Search starts at r_ptr and wraps, so the requester after the last winner has priority.
   always_comb begin
      w_found    = 1'b0;
      w_win      = '0;
      w_win_data = '0;
      w_idx      = 0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= N_REQ) begin
            w_idx = w_idx - N_REQ;
         end
         if (!w_found && req[w_idx]) begin
            w_found    = 1'b1;
            w_win      = PTR_W'(w_idx);
            w_win_data = req_data[16*w_idx +: 16];
         end
      end
   end

   assign w_win_oh   = N_REQ'(1) << w_win;
   assign w_next_ptr = (w_win == PTR_W'(N_REQ-1)) ? '0 : w_win + 1'b1;

   and16 u_and16 (
      .a (r_operand),
      .y (w_and_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_gnt       <= '0;
         r_rsp_valid <= '0;
         r_rsp_y     <= 1'b0;
         r_busy      <= 1'b0;
         r_op_count  <= '0;
         r_ptr       <= '0;
         r_idx       <= '0;
         r_operand   <= '0;
      end else begin
         case (r_state)
            IDLE, RESP: begin
               r_rsp_valid <= '0;
               if (w_found) begin
                  r_state   <= GRANT;
                  r_gnt     <= w_win_oh;
                  r_operand <= w_win_data;
                  r_idx     <= w_win;
                  r_ptr     <= w_next_ptr;
                  r_busy    <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
               end
            end
            GRANT: begin
               // req is not looked at here; the operand was captured at the grant edge.
               r_state     <= RESP;
               r_gnt       <= '0;
               r_rsp_valid <= N_REQ'(1) << r_idx;
               r_rsp_y     <= w_and_y;
               r_op_count  <= r_op_count + 16'd1;
               r_busy      <= 1'b1;
            end
            default: begin
               r_state     <= IDLE;
               r_gnt       <= '0;
               r_rsp_valid <= '0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign rsp_valid = r_rsp_valid;
   assign rsp_y     = r_rsp_y;
   assign busy      = r_busy;
   assign op_count  = r_op_count;

endmodule

// File: tb/tb_and16_rr_arbiter.sv
// Scoreboard bench for and16_rr_arbiter: directed stimulus pushes expected grants/results,
// a negedge monitor pops and compares whenever gnt or rsp_valid is nonzero.

module tb_and16_rr_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [63:0] req_data;
   logic [3:0]  gnt;
   logic [3:0]  rsp_valid;
   logic        rsp_y;
   logic        busy;
   logic [15:0] op_count;

   typedef struct {
      logic [3:0]  vec;
      logic        y;
      logic [15:0] cnt;
      int          cyc;
   } exp_t;

   exp_t        gnt_q[$];
   exp_t        rsp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [15:0] exp_cnt = 16'd0;

   and16_rr_arbiter #(.N_REQ(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_y     (rsp_y),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Queue one grant and its result; gnt expected at cycle c, result at c+1.
   task automatic expect_op(input logic [3:0] vec, input logic y, input int c);
      exp_t e;
      exp_cnt++;
      e.vec = vec; e.y = y; e.cnt = exp_cnt; e.cyc = c;
      gnt_q.push_back(e);
      e.cyc = c + 1;
      rsp_q.push_back(e);
   endtask

   // Single-requester operation; called 1 time unit after a rising edge.
   task automatic op(input int idx, input logic [15:0] d, input logic exp_y);
      logic [3:0] oh;
      oh = 4'b0001 << idx;
      req_data[16*idx +: 16] = d;
      req = oh;
      expect_op(oh, exp_y, cyc + 1);
      @(posedge clk); #1;
      req = 4'b0000;
      req_data[16*idx +: 16] = ~d;
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1) begin
         if (gnt !== 4'b0000) begin
            chk("gnt_rsp_overlap", {28'd0, gnt & rsp_valid}, 32'd0);
            chk("busy_in_grant", {31'd0, busy}, 32'd1);
            if (gnt_q.size() == 0) begin
               chk("gnt_unexpected", {28'd0, gnt}, 32'd0);
            end else begin
               e = gnt_q.pop_front();
               chk("gnt_vec", {28'd0, gnt}, {28'd0, e.vec});
               chk("gnt_cyc", cyc, e.cyc);
            end
         end
         if (rsp_valid !== 4'b0000) begin
            if (rsp_q.size() == 0) begin
               chk("rsp_unexpected", {28'd0, rsp_valid}, 32'd0);
            end else begin
               e = rsp_q.pop_front();
               chk("rsp_vec", {28'd0, rsp_valid}, {28'd0, e.vec});
               chk("rsp_y", {31'd0, rsp_y}, {31'd0, e.y});
               chk("rsp_cnt", {16'd0, op_count}, {16'd0, e.cnt});
               chk("rsp_cyc", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      int k;
      rst_n    = 1'b0;
      req      = 4'b0000;
      req_data = 64'd0;
      #1;
      chk("rst_gnt", {28'd0, gnt}, 32'd0);
      chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_y", {31'd0, rsp_y}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_op_count", {16'd0, op_count}, 32'd0);
      #12 rst_n = 1'b1;
      @(posedge clk); #1;

      // All-ones operand gives 1; data changed during GRANT must not matter.
      op(0, 16'hFFFF, 1'b1);

      // Every single-zero-bit operand and all-zero give 0 (ptr ends at 2).
      for (int b = 0; b < 16; b++) begin
         op(1, ~(16'h0001 << b), 1'b0);
      end
      op(1, 16'h0000, 1'b0);

      // ptr=2 with req=1001: index 3 first, then wrap to 0.
      req_data[63:48] = 16'hFFFF;
      req_data[15:0]  = 16'h7FFF;
      k = cyc;
      expect_op(4'b1000, 1'b1, k + 1);
      expect_op(4'b0001, 1'b0, k + 3);
      req = 4'b1001;
      repeat (4) @(posedge clk);
      #1 req = 4'b0000;
      repeat (2) @(posedge clk); #1;

      // Reset in GRANT discards the operation and clears the pointer.
      req_data[47:32] = 16'hFFFF;
      req = 4'b0100;
      @(posedge clk); #2;
      chk("pre_rst_gnt", {28'd0, gnt}, 32'h4);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_gnt", {28'd0, gnt}, 32'd0);
      chk("async_rsp_valid", {28'd0, rsp_valid}, 32'd0);
      chk("async_busy", {31'd0, busy}, 32'd0);
      chk("async_op_count", {16'd0, op_count}, 32'd0);
      req = 4'b0000;
      exp_cnt = 16'd0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      chk("post_rst_op_count", {16'd0, op_count}, 32'd0);
      chk("post_rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);

      // Four continuous requesters rotate starting at index 0.
      req_data = {4{16'hFFFF}};
      k = cyc;
      expect_op(4'b0001, 1'b1, k + 1);
      expect_op(4'b0010, 1'b1, k + 3);
      expect_op(4'b0100, 1'b1, k + 5);
      expect_op(4'b1000, 1'b1, k + 7);
      expect_op(4'b0001, 1'b1, k + 9);
      req = 4'b1111;
      repeat (10) @(posedge clk);
      #1 req = 4'b0000;
      repeat (2) @(posedge clk); #1;

      // Counter wrap: preload near the top, then three operations.
      force dut.r_op_count = 16'hFFFE;
      #1 release dut.r_op_count;
      exp_cnt = 16'hFFFE;
      op(2, 16'hFFFF, 1'b1);
      op(2, 16'hFFFF, 1'b1);
      op(2, 16'h8001, 1'b0);
      repeat (3) @(posedge clk); #1;
      chk("final_op_count", {16'd0, op_count}, 32'h0001);
      chk("gnt_q_drained", gnt_q.size(), 32'd0);
      chk("rsp_q_drained", rsp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/and16_rr_arbiter.md
AND16_RR_ARBITER -- requirements
Module: and16_rr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, legal range 2..8: number of requesters sharing one and16 reduction unit.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  N_REQ  per-requester request, level.
REQ-005 SHALL have port req_data  input  16*N_REQ  operands; requester i owns bits [16*i+15:16*i].
REQ-006 SHALL have port gnt  output  N_REQ  registered one-hot grant pulse.
REQ-007 SHALL have port rsp_valid  output  N_REQ  registered one-hot result strobe.
REQ-008 SHALL have port rsp_y  output  1  registered AND-reduction result; meaningful only while rsp_valid is nonzero.
REQ-009 SHALL have port busy  output  1  high in GRANT and RESP states.
REQ-010 SHALL have port op_count  output  16  number of completed operations, modulo 2^16.

Function
REQ-011 SHALL instantiate exactly one and16 (a: 16-bit in, y: 1-bit out) as the only reduction datapath.
REQ-012 SHALL implement FSM states IDLE, GRANT, RESP.
REQ-013 SHALL arbitrate in IDLE and RESP: if req is nonzero, select the winner, move to GRANT, set gnt to the winner's one-hot, latch the winner's req_data into a 16-bit operand register, and latch the winner index.
REQ-014 In IDLE and RESP with req == 0, SHALL go to or stay in IDLE with gnt = 0.
REQ-015 SHALL move unconditionally from GRANT to RESP, drive the operand register into and16.a, and register and16.y into rsp_y.
REQ-016 In RESP, SHALL assert rsp_valid for exactly one cycle, at the latched winner bit only, and increment op_count by 1; 16'hFFFF increments to 16'h0000.
REQ-017 SHALL keep gnt high for exactly one cycle per operation; gnt and rsp_valid are never high in the same cycle.
REQ-018 Latency: req sampled at edge E gives gnt in cycle E+1 and rsp_valid/rsp_y in cycle E+2; sustained throughput is one operation per 2 cycles.
REQ-019 SHALL arbitrate round-robin: search starts at pointer ptr and wraps from N_REQ-1 to 0; after granting index i, ptr = (i+1) mod N_REQ.
REQ-020 SHALL not update ptr when no grant is issued.
REQ-021 Requester contract: hold req and req_data stable until gnt is seen, and drop req at the edge ending the gnt cycle unless it wants another operation. The block SHALL sample req_data only at the grant edge; later changes do not affect rsp_y.
REQ-022 SHALL hold rsp_y at its last value outside RESP.
REQ-023 SHALL ignore req changes during GRANT.
REQ-024 With N_REQ continuously active requesters, SHALL grant each exactly once in every N_REQ consecutive grants (no starvation).

Reset
REQ-025 rst_n low SHALL immediately, without waiting for a clock edge, force: state IDLE, gnt 0, rsp_valid 0, rsp_y 0, busy 0, op_count 0, ptr 0, operand register 0.
REQ-026 Reset asserted in GRANT or RESP SHALL discard the in-flight operation: no rsp_valid after release, and op_count is not incremented.
REQ-027 The first arbitration SHALL occur at the first rising edge with rst_n high.

Verification
REQ-028 req=0001, data0=16'hFFFF -> gnt=0001 in the next cycle, then rsp_valid=0001 with rsp_y=1, op_count=1.
REQ-029 req=0010, data1=16'hFFFE; repeat with each single-zero-bit pattern and 16'h0000 -> rsp_y=0 in every case.
REQ-030 req=1111 held continuously, all data 16'hFFFF -> gnt sequence 0001,0010,0100,1000,0001 at 2-cycle spacing, each followed by the matching rsp_valid.
REQ-031 ptr=2 (after granting req1), then req=1001 -> grant 1000 first, then 0001.
REQ-032 rst_n pulled low mid-cycle during GRANT -> gnt and rsp_valid go to 0 before the next edge; after release no rsp_valid occurs and op_count=0; the next request with req=1111 is granted to index 0.
REQ-033 Run 65536 completed operations -> op_count returns to 16'h0000; operation 65537 -> 16'h0001.
